// File: rtl/gpr_param.sv
// rtl/gpr_param.sv - parametrised GPR file with 2R/1W ports, merge writes, bypass and busy scoreboard
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset (clears data and busy)
//   swp12      in   swap read outputs (data and busy) between ports 1 and 2
//   wd         in   write data
//   reg_w      in   write mode: 00 none, 01 low byte, 10 low half, 11 full word
//   a1, a2     in   read addresses
//   a3         in   write address
//   set_busy   in   mark busy_addr busy at the edge
//   busy_addr  in   register to mark busy
//   rd1, rd2   out  read data after swap
//   rd1_busy   out  busy flag of the register feeding rd1
//   rd2_busy   out  busy flag of the register feeding rd2

module gpr_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              swp12,
    input  logic [DATA_W-1:0] wd,
    input  logic [1:0]        reg_w,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    input  logic              set_busy,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rd1_busy,
    output logic              rd2_busy
);

    localparam int NREG   = 2 ** ADDR_W;
    localparam bit BYP_EN = (BYPASS != 0);
    localparam bit ZR_EN  = (ZERO_REG != 0);

    // Byte/half lane masks built by zero-extension so they stay legal for DATA_W=16.
    localparam logic [DATA_W-1:0] MASK_B = {{(DATA_W-8){1'b0}}, 8'hFF};
    localparam logic [DATA_W-1:0] MASK_H = {{(DATA_W-16){1'b0}}, 16'hFFFF};

    logic [NREG-1:0][DATA_W-1:0] regs_q;
    logic [NREG-1:0][DATA_W-1:0] regs_d;
    logic [NREG-1:0]             busy_q;
    logic [NREG-1:0]             busy_d;

    logic              wr_any;
    logic              wr_en;
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] wr_merged;

    logic [DATA_W-1:0] p1_data;
    logic [DATA_W-1:0] p2_data;
    logic              p1_busy;
    logic              p2_busy;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return ZR_EN && (a == '0);
    endfunction

    // Write path: merge new lanes into the currently stored value so upper
    // bits are kept untouched on partial writes.
    always_comb begin
        wr_mask = '1;
        case (reg_w)
            2'b01:   wr_mask = MASK_B;
            2'b10:   wr_mask = MASK_H;
            default: wr_mask = '1;
        endcase
        wr_any    = (reg_w != 2'b00);
        wr_en     = wr_any && !is_zero_reg(a3);
        wr_merged = (regs_q[a3] & ~wr_mask) | (wd & wr_mask);
    end

    // Next state. A write to a3 retires any outstanding producer, but a
    // set_busy in the same cycle represents a newer producer and wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[a3] = wr_merged;
        end
        if (wr_any) begin
            busy_d[a3] = 1'b0;
        end
        if (set_busy && !is_zero_reg(busy_addr)) begin
            busy_d[busy_addr] = 1'b1;
        end
        if (ZR_EN) begin
            regs_d[0] = '0;
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports. Data may be forwarded from the in-flight write; busy is
    // always the registered flag so a same-cycle write does not hide it.
    always_comb begin
        p1_data = regs_q[a1];
        if (BYP_EN && wr_en && (a3 == a1)) begin
            p1_data = wr_merged;
        end
        if (is_zero_reg(a1)) begin
            p1_data = '0;
        end
        p1_busy = busy_q[a1] && !is_zero_reg(a1);

        p2_data = regs_q[a2];
        if (BYP_EN && wr_en && (a3 == a2)) begin
            p2_data = wr_merged;
        end
        if (is_zero_reg(a2)) begin
            p2_data = '0;
        end
        p2_busy = busy_q[a2] && !is_zero_reg(a2);
    end

    // Output swap moves data and busy together.
    always_comb begin
        rd1      = swp12 ? p2_data : p1_data;
        rd2      = swp12 ? p1_data : p2_data;
        rd1_busy = swp12 ? p2_busy : p1_busy;
        rd2_busy = swp12 ? p1_busy : p2_busy;
    end

endmodule

// File: tb/tb_gpr_param.sv
// tb/tb_gpr_param.sv - scoreboard bench for gpr_param, bypass and non-bypass instances

module tb_gpr_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        swp12;
    logic [31:0] wd;
    logic [1:0]  reg_w;
    logic [4:0]  a1, a2, a3;
    logic        set_busy;
    logic [4:0]  busy_addr;

    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        rd1_busy_b, rd2_busy_b, rd1_busy_n, rd2_busy_n;

    always #5 clk = ~clk;

    gpr_param #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) u_byp (
        .clk(clk), .reset(reset), .swp12(swp12), .wd(wd), .reg_w(reg_w),
        .a1(a1), .a2(a2), .a3(a3), .set_busy(set_busy), .busy_addr(busy_addr),
        .rd1(rd1_b), .rd2(rd2_b), .rd1_busy(rd1_busy_b), .rd2_busy(rd2_busy_b)
    );

    gpr_param #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(1)) u_nob (
        .clk(clk), .reset(reset), .swp12(swp12), .wd(wd), .reg_w(reg_w),
        .a1(a1), .a2(a2), .a3(a3), .set_busy(set_busy), .busy_addr(busy_addr),
        .rd1(rd1_n), .rd2(rd2_n), .rd1_busy(rd1_busy_n), .rd2_busy(rd2_busy_n)
    );

    typedef struct packed {
        logic [31:0] r1;
        logic [31:0] r2;
        logic        b1;
        logic        b2;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_reg [32];
    logic        m_busy[32];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_merge(input logic [1:0] m, input logic [31:0] old, input logic [31:0] d);
        case (m)
            2'b01:   return {old[31:8], d[7:0]};
            2'b10:   return {old[31:16], d[15:0]};
            2'b11:   return d;
            default: return old;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && reg_w != 2'b00 && a3 == a) return m_merge(reg_w, m_reg[a], wd);
        return m_reg[a];
    endfunction

    function automatic exp_t m_port(input bit byp);
        exp_t e;
        logic [31:0] p1, p2;
        logic        b1, b2;
        p1 = m_read(a1, byp);
        p2 = m_read(a2, byp);
        b1 = m_busy[a1];
        b2 = m_busy[a2];
        e.r1 = swp12 ? p2 : p1;
        e.r2 = swp12 ? p1 : p2;
        e.b1 = swp12 ? b2 : b1;
        e.b2 = swp12 ? b1 : b2;
        return e;
    endfunction

    task automatic m_commit();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = 32'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (reg_w != 2'b00 && a3 != 5'd0) m_reg[a3] = m_merge(reg_w, m_reg[a3], wd);
            if (reg_w != 2'b00) m_busy[a3] = 1'b0;
            if (set_busy && busy_addr != 5'd0) m_busy[busy_addr] = 1'b1;
        end
    endtask

    // One clock cycle: drive at the falling edge, queue expectations, sample
    // 2ns later, then advance the model to the state after the next rising edge.
    task automatic cyc(input logic r, input logic [1:0] m, input logic [31:0] d,
                       input logic [4:0] x3, input logic [4:0] x1, input logic [4:0] x2,
                       input logic s, input logic sb, input logic [4:0] ba, input string tag);
        exp_t e;
        @(negedge clk);
        reset = r; reg_w = m; wd = d; a3 = x3; a1 = x1; a2 = x2;
        swp12 = s; set_busy = sb; busy_addr = ba;
        exp_q.push_back(m_port(1'b1));
        exp_q.push_back(m_port(1'b0));
        #2;
        e = exp_q.pop_front();
        chk({tag, ".byp.rd1"}, rd1_b, e.r1);
        chk({tag, ".byp.rd2"}, rd2_b, e.r2);
        chk({tag, ".byp.b1"}, {31'b0, rd1_busy_b}, {31'b0, e.b1});
        chk({tag, ".byp.b2"}, {31'b0, rd2_busy_b}, {31'b0, e.b2});
        e = exp_q.pop_front();
        chk({tag, ".nob.rd1"}, rd1_n, e.r1);
        chk({tag, ".nob.rd2"}, rd2_n, e.r2);
        chk({tag, ".nob.b1"}, {31'b0, rd1_busy_n}, {31'b0, e.b1});
        chk({tag, ".nob.b2"}, {31'b0, rd2_busy_n}, {31'b0, e.b2});
        m_commit();
    endtask

    initial begin
        reset = 1'b1; reg_w = 2'b00; wd = '0; a1 = 5'd8; a2 = 5'd0; a3 = '0;
        swp12 = 1'b0; set_busy = 1'b0; busy_addr = '0;
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
        @(posedge clk);

        cyc(1, 2'b00, 32'h0, 5'd0, 5'd8, 5'd0, 0, 0, 5'd0, "rst");
        // Spot checks on fixed constants, independent of the model.
        chk("rst.rd1_const", rd1_b, 32'h0);
        cyc(0, 2'b11, 32'hAAAAAAAA, 5'd8, 5'd8, 5'd0, 0, 0, 5'd0, "wr8");
        chk("wr8.byp_const", rd1_b, 32'hAAAAAAAA);
        chk("wr8.nob_const", rd1_n, 32'h0);
        cyc(0, 2'b00, 32'h0, 5'd0, 5'd8, 5'd0, 0, 0, 5'd0, "rd8");
        chk("rd8.const", rd1_n, 32'hAAAAAAAA);

        cyc(0, 2'b11, 32'h12345678, 5'd9, 5'd9, 5'd8, 0, 0, 5'd0, "wr9");
        cyc(0, 2'b01, 32'hFFFFFF9A, 5'd9, 5'd9, 5'd8, 0, 0, 5'd0, "byte9");
        cyc(0, 2'b10, 32'h0000BEEF, 5'd9, 5'd9, 5'd8, 0, 0, 5'd0, "half9");
        chk("byte9.const", rd1_n, 32'h1234569A);
        cyc(0, 2'b00, 32'h0, 5'd0, 5'd9, 5'd8, 0, 0, 5'd0, "rd9");
        chk("half9.const", rd1_n, 32'h1234BEEF);

        cyc(0, 2'b00, 32'h0, 5'd0, 5'd6, 5'd8, 1, 0, 5'd0, "swap");
        chk("swap.rd1_const", rd1_n, 32'hAAAAAAAA);
        chk("swap.rd2_const", rd2_n, 32'h0);
        cyc(0, 2'b11, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd8, 0, 0, 5'd0, "wr0");
        cyc(0, 2'b00, 32'h0, 5'd0, 5'd0, 5'd8, 0, 0, 5'd0, "rd0");
        chk("rd0.const", rd1_b, 32'h0);

        cyc(0, 2'b11, 32'h00000055, 5'd5, 5'd0, 5'd5, 0, 0, 5'd0, "byp5");
        chk("byp5.byp_const", rd2_b, 32'h55);
        chk("byp5.nob_const", rd2_n, 32'h0);
        cyc(0, 2'b00, 32'h0, 5'd0, 5'd0, 5'd5, 0, 0, 5'd0, "rd5");

        cyc(0, 2'b00, 32'h0, 5'd0, 5'd7, 5'd0, 0, 1, 5'd7, "sb7");
        cyc(0, 2'b00, 32'h0, 5'd0, 5'd7, 5'd0, 0, 0, 5'd0, "busy7");
        chk("busy7.const", {31'b0, rd1_busy_b}, 32'h1);
        cyc(0, 2'b11, 32'h00000077, 5'd7, 5'd7, 5'd7, 0, 0, 5'd0, "wr7");
        cyc(0, 2'b00, 32'h0, 5'd0, 5'd7, 5'd0, 0, 0, 5'd0, "clr7");
        chk("clr7.const", {31'b0, rd1_busy_b}, 32'h0);
        cyc(0, 2'b11, 32'h00000078, 5'd7, 5'd7, 5'd0, 0, 1, 5'd7, "sbwr7");
        cyc(0, 2'b00, 32'h0, 5'd0, 5'd7, 5'd0, 1, 1, 5'd0, "set7");
        chk("set7.swapped_const", {31'b0, rd2_busy_b}, 32'h1);
        cyc(0, 2'b00, 32'h0, 5'd0, 5'd0, 5'd7, 0, 0, 5'd0, "busy0");
        chk("busy0.const", {31'b0, rd1_busy_b}, 32'h0);

        cyc(0, 2'b11, 32'h00000033, 5'd3, 5'd3, 5'd0, 0, 1, 5'd4, "wr3");
        cyc(1, 2'b11, 32'h00000001, 5'd3, 5'd8, 5'd4, 0, 1, 5'd3, "rst3");
        cyc(0, 2'b00, 32'h0, 5'd0, 5'd3, 5'd8, 0, 0, 5'd0, "post3");
        chk("post3.data_const", rd1_b, 32'h0);
        chk("post3.busy_const", {31'b0, rd1_busy_b}, 32'h0);

        for (int k = 0; k < 40; k++) begin
            cyc(0, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
